// File: rtl/esc_pt_pkg.sv
// Shared types and constants for the ESC passthrough sequencer.
package esc_pt_pkg;

   // Sequencer states; the numeric codes are visible in STATUS[2:0].
   typedef enum logic [2:0] {
      ST_DSHOT   = 3'd0,
      ST_DRAIN   = 3'd1,
      ST_GUARD   = 3'd2,
      ST_PASS    = 3'd3,
      ST_RELEASE = 3'd4
   } state_e;

   // Register word offsets (wb_adr_i[3:2]).
   localparam logic [1:0] OFF_CTRL    = 2'd0;
   localparam logic [1:0] OFF_STATUS  = 2'd1;
   localparam logic [1:0] OFF_TIMEOUT = 2'd2;
   localparam logic [1:0] OFF_RSVD    = 2'd3;

   // CTRL bit positions.
   localparam int CTRL_REQ_BIT = 0;
   localparam int CTRL_CH_LSB  = 1;

   // STATUS bit positions.
   localparam int STATUS_STATE_LSB = 0;
   localparam int STATUS_TO_BIT    = 3;
   localparam int STATUS_CH_LSB    = 4;

   // Assemble the STATUS read word.
   function automatic logic [31:0] pack_status(input state_e st, input logic to_flag,
                                               input logic [1:0] ch);
      logic [31:0] w;
      w = 32'd0;
      w[STATUS_STATE_LSB +: 3] = st;
      w[STATUS_TO_BIT]         = to_flag;
      w[STATUS_CH_LSB +: 2]    = ch;
      return w;
   endfunction

endpackage

// File: rtl/esc_pt_idle_timer.sv
// Serial inactivity timer: a tick prescaler feeding a saturating idle tick
// counter. Both are held at zero while disabled or cleared, so every entry
// into passthrough and every line activity starts a fresh timeout window.
module esc_pt_idle_timer
   import esc_pt_pkg::*;
#(
   parameter int TICK_CYCLES = 72000
) (
   input  logic        i_clk,
   input  logic        i_rst,
   input  logic        i_en,
   input  logic        i_clr,
   input  logic [15:0] i_timeout,
   output logic        o_tc
);

   localparam int            PW       = (TICK_CYCLES > 1) ? $clog2(TICK_CYCLES) : 1;
   localparam logic [PW-1:0] PRE_LAST = PW'(TICK_CYCLES - 1);

   logic [PW-1:0] r_pre;
   logic [15:0]   r_idle;
   logic          w_tick;
   logic          w_near;

   assign w_tick = i_en & (r_pre == PRE_LAST);
   // The tick that brings the idle count up to the limit is the terminal one;
   // ">=" keeps it firing if the limit is lowered below the current count.
   assign w_near = ({1'b0, r_idle} + 17'd1) >= {1'b0, i_timeout};
   // Activity in the same cycle always suppresses the terminal count.
   assign o_tc   = w_tick & ~i_clr & (i_timeout != 16'd0) & w_near;

   // Prescaler and idle tick counter.
   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         r_pre  <= {PW{1'b0}};
         r_idle <= 16'd0;
      end else if (!i_en || i_clr) begin
         r_pre  <= {PW{1'b0}};
         r_idle <= 16'd0;
      end else if (w_tick) begin
         r_pre <= {PW{1'b0}};
         if (r_idle != 16'hFFFF) begin
            r_idle <= r_idle + 16'd1;
         end
      end else begin
         r_pre <= r_pre + PW'(1);
      end
   end

endmodule

// File: rtl/esc_passthrough_sequencer.sv
// Moves one motor pad between DSHOT drive and serial passthrough: drains the
// DSHOT frame, forces an idle-high guard, hands the pad to the serial bridge,
// and returns to DSHOT on host request or serial inactivity.
module esc_passthrough_sequencer
   import esc_pt_pkg::*;
#(
   parameter logic [7:0]  BASE_ADR     = 8'h50,
   parameter int          GUARD_CYCLES = 1000,
   parameter int          TICK_CYCLES  = 72000,
   parameter logic [15:0] DEF_TIMEOUT  = 16'd5000
) (
   input  logic        wb_clk_i,
   input  logic        wb_rst_i,
   input  logic [31:0] wb_adr_i,
   input  logic [31:0] wb_dat_i,
   input  logic        wb_we_i,
   input  logic [3:0]  wb_sel_i,
   input  logic        wb_stb_i,
   input  logic        wb_cyc_i,
   output logic [31:0] wb_dat_o,
   output logic        wb_ack_o,
   output logic        wb_stall_o,
   input  logic        dshot_busy_i,
   input  logic        serial_act_i,
   input  logic        bridge_tx_i,
   input  logic        bridge_oe_i,
   output logic        dshot_inhibit_o,
   output logic        mux_sel_o,
   output logic [1:0]  mux_ch_o,
   output logic        serial_tx_o,
   output logic        serial_oe_o
);

   localparam int            GW         = (GUARD_CYCLES > 1) ? $clog2(GUARD_CYCLES) : 1;
   localparam logic [GW-1:0] GUARD_LOAD = GW'(GUARD_CYCLES - 1);

   state_e        r_state;
   state_e        w_state_nx;
   logic          r_req;
   logic [1:0]    r_ch;
   logic [15:0]   r_timeout;
   logic          r_to_flag;
   logic [1:0]    r_mux_ch;
   logic [GW-1:0] r_guard;
   logic          r_sel;
   logic          r_inh;
   logic          r_force;
   logic          r_pass;
   logic          r_ack;
   logic [31:0]   r_dat;

   logic          w_hit;
   logic          w_ctrl_wr;
   logic          w_tmo_wr;
   logic          w_tc;
   logic          w_timeout;
   logic          w_enter_guard;
   logic [31:0]   w_rdata;
   logic          w_unused;

   // Only the word offset and block-select address bits and the low data bits matter.
   assign w_unused = ^{wb_sel_i, wb_adr_i[31:12], wb_adr_i[1:0], wb_dat_i[31:16]};

   assign w_hit     = wb_cyc_i & wb_stb_i & (wb_adr_i[11:4] == BASE_ADR);
   assign w_ctrl_wr = w_hit & wb_we_i & (wb_adr_i[3:2] == OFF_CTRL);
   assign w_tmo_wr  = w_hit & wb_we_i & (wb_adr_i[3:2] == OFF_TIMEOUT);

   esc_pt_idle_timer #(
      .TICK_CYCLES (TICK_CYCLES)
   ) u_idle_timer (
      .i_clk     (wb_clk_i),
      .i_rst     (wb_rst_i),
      .i_en      (r_state == ST_PASS),
      .i_clr     (serial_act_i),
      .i_timeout (r_timeout),
      .o_tc      (w_tc)
   );

   // A host CTRL write landing on the terminal tick takes precedence over the timeout.
   assign w_timeout = (r_state == ST_PASS) & r_req & w_tc & ~w_ctrl_wr;

   // Register read multiplexer.
   always_comb begin
      w_rdata = 32'd0;
      case (wb_adr_i[3:2])
         OFF_CTRL:    w_rdata = {29'd0, r_ch, r_req};
         OFF_STATUS:  w_rdata = pack_status(r_state, r_to_flag, r_mux_ch);
         OFF_TIMEOUT: w_rdata = {16'd0, r_timeout};
         default:     w_rdata = 32'd0;
      endcase
   end

   // Bus ack and registered read data, one cycle after a selected strobe.
   always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
      if (wb_rst_i) begin
         r_ack <= 1'b0;
         r_dat <= 32'd0;
      end else begin
         r_ack <= w_hit;
         r_dat <= w_hit ? w_rdata : 32'd0;
      end
   end

   // Host-visible control registers and the sticky timeout flag.
   always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
      if (wb_rst_i) begin
         r_req     <= 1'b0;
         r_ch      <= 2'd0;
         r_timeout <= DEF_TIMEOUT;
         r_to_flag <= 1'b0;
      end else begin
         if (w_ctrl_wr) begin
            r_req     <= wb_dat_i[CTRL_REQ_BIT];
            r_ch      <= wb_dat_i[CTRL_CH_LSB +: 2];
            r_to_flag <= 1'b0;
         end else if (w_timeout) begin
            r_req     <= 1'b0;
            r_to_flag <= 1'b1;
         end
         if (w_tmo_wr) begin
            r_timeout <= wb_dat_i[15:0];
         end
      end
   end

   // Next-state logic of the handover sequence.
   always_comb begin
      w_state_nx = r_state;
      case (r_state)
         ST_DSHOT: begin
            if (r_req) w_state_nx = ST_DRAIN;
            else       w_state_nx = ST_DSHOT;
         end
         ST_DRAIN: begin
            if (!r_req)            w_state_nx = ST_DSHOT;
            else if (!dshot_busy_i) w_state_nx = ST_GUARD;
            else                    w_state_nx = ST_DRAIN;
         end
         ST_GUARD: begin
            if (!r_req)                       w_state_nx = ST_RELEASE;
            else if (r_guard == {GW{1'b0}})   w_state_nx = ST_PASS;
            else                              w_state_nx = ST_GUARD;
         end
         ST_PASS: begin
            if (!r_req || w_timeout)  w_state_nx = ST_RELEASE;
            else if (r_ch != r_mux_ch) w_state_nx = ST_GUARD;
            else                       w_state_nx = ST_PASS;
         end
         ST_RELEASE: w_state_nx = ST_DSHOT;
         default:    w_state_nx = ST_RELEASE;
      endcase
   end

   assign w_enter_guard = (w_state_nx == ST_GUARD) && (r_state != ST_GUARD);

   // State, guard counter, channel latch and registered pad controls.
   always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
      if (wb_rst_i) begin
         r_state  <= ST_DSHOT;
         r_sel    <= 1'b1;
         r_inh    <= 1'b0;
         r_force  <= 1'b0;
         r_pass   <= 1'b0;
         r_mux_ch <= 2'd0;
         r_guard  <= {GW{1'b0}};
      end else begin
         r_state <= w_state_nx;
         r_sel   <= (w_state_nx == ST_DSHOT) || (w_state_nx == ST_DRAIN);
         r_inh   <= (w_state_nx != ST_DSHOT);
         r_force <= (w_state_nx == ST_GUARD);
         r_pass  <= (w_state_nx == ST_PASS);
         if (w_enter_guard) begin
            r_mux_ch <= r_ch;
            r_guard  <= GUARD_LOAD;
         end else if ((r_state == ST_GUARD) && (r_guard != {GW{1'b0}})) begin
            r_guard <= r_guard - GW'(1);
         end
      end
   end

   assign wb_ack_o        = r_ack;
   assign wb_dat_o        = r_dat;
   assign wb_stall_o      = 1'b0;
   assign mux_sel_o       = r_sel;
   assign dshot_inhibit_o = r_inh;
   assign mux_ch_o        = r_mux_ch;
   // Bridge owns the pad only in passthrough; otherwise the line idles high.
   assign serial_tx_o     = r_pass ? bridge_tx_i : 1'b1;
   assign serial_oe_o     = r_pass ? bridge_oe_i : r_force;

endmodule
